uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx byte transmitter between N_REQ byte-stream requesters (register-file dump, status/echo messages, debug). Grants whole frames round-robin, sequences each byte through the uart_tx data/start/ready handshake, and releases the link on the frame's last byte. Sits between the requester blocks and the single uart_tx instance at the top level.

Parameters:
N_REQ, 2, number of requesters (2..8)
PTR_W, $clog2(N_REQ) (min 1), width of the round-robin pointer and requester ID

Ports:
clk12  input  1  system clock
rst  input  1  synchronous reset, active-high
req  input  N_REQ  per-requester frame request; held high for the whole frame
req_data  input  8*N_REQ  per-requester current byte; requester i uses bits [8*i +: 8]
req_last  input  N_REQ  current byte of requester i is the last byte of its frame
req_ack  output  N_REQ  one-cycle pulse: current byte latched; requester presents its next byte on the following cycle
grant  output  N_REQ  one-hot owner of the link, zero when idle
busy  output  1  high whenever state != IDLE
tx_data  output  8  byte to uart_tx, stable from LOAD until the next LOAD
tx_start  output  1  start strobe to uart_tx
tx_ready  input  1  uart_tx idle flag; drops low once a byte is accepted

Behaviour:
- Reset values: grant=0, req_ack=0, tx_start=0, tx_data=8'h00, busy=0, rr pointer=0, state=IDLE.
- States: IDLE, HDR (optional), LOAD, START, WAIT.
- IDLE: if any req and tx_ready==1, pick the first set req at or after the pointer (wrapping), set grant next cycle, go to LOAD (HDR if the feature is enabled). Without tx_ready==1 nothing is granted.
- LOAD (1 cycle): tx_data<=granted req_data byte; last_q<=req_last[g]; req_ack[g]=1 this cycle; go to START.
- START: tx_start=1. Stay until tx_ready==0 is sampled, then go to WAIT with tx_start=0.
- WAIT: on tx_ready==1:
  - If last_q==1 or req[g]==0 (abort), go to IDLE, clear grant, pointer<=g+1 mod N_REQ.
  - Otherwise go to LOAD.
- Latency: req rising in IDLE gives grant after 1 cycle, req_ack after 2 cycles, and tx_start from cycle 3.
- Grant is frame-locked. A higher-priority req arriving mid-frame waits.
- Abort: if req[g] drops mid-frame, the byte already latched still completes and no further ack is issued.
- Simultaneous requests: the round-robin order is fixed by the pointer. The same requester cannot win twice in a row while another is requesting.
- req_last sampled high together with req_ack marks a 1-byte frame; this is legal.
- Reset mid-frame: return to IDLE immediately and drop tx_start. uart_tx may still be shifting out its byte. IDLE's tx_ready==1 gate guarantees no start is issued until it finishes.
- req_data/req_last of non-granted requesters are ignored.

Optional Feature:
UART_ARB_FRAME_HEADER_EN
- Defined: after each grant, state HDR sends one header byte {4'hA, 1'b0, ID (zero-extended to 3 bits)} through the START/WAIT path before the first LOAD. The header issues no req_ack. If req[g] drops during the header, the frame aborts after the header byte.
- Undefined: the HDR state is absent; IDLE goes directly to LOAD.

Decomposition:
- Shared package/include uart_arb_defs: state encodings, HDR_MAGIC=4'hA, and the header-byte builder function.
- One sub-module, rr_pick: a combinational round-robin picker (req vector and pointer in, one-hot plus ID out). It is reusable by other shared-resource arbiters.
- uart_tx stays outside. The bench drives a behavioural uart_tx model in which ready drops 1 cycle after start and rises again after 10 bit-times.

Test Plan:
- Single 3-byte frame from req0 (8'h11, 8'h22, 8'h33 with last): 3 acks and 3 tx_start bursts in order. grant returns to 0 one cycle after the third tx_ready rise; pointer=1.
- req0 and req1 asserted together (pointer=0): req0's full frame goes out before req1 is granted. With both still requesting afterwards, req1 wins next.
- req0 drops after its first ack: byte 1 completes, no second ack, grant is cleared, and req1 is granted next if pending.
- rst pulsed while in WAIT with tx_ready=0: state=IDLE and tx_start=0 next cycle. No grant until the model raises tx_ready.
- 1-byte frame (req_last high on first byte, data 8'h5A): exactly one start, and busy is high for the exact transmission window.
- With UART_ARB_FRAME_HEADER_EN, requester 1 sends a 1-byte frame: wire sequence is 8'hA1 then the data byte, with one req_ack.

Source files
------------

// File: rtl/uart_arb_defs_pkg.sv
// Shared definitions for the uart_tx frame arbiter: FSM state encoding,
// header magic nibble and the header-byte builder.
// Optional macro UART_ARB_FRAME_HEADER_EN adds the HDR state to the encoding.
package uart_arb_defs;

`ifdef UART_ARB_FRAME_HEADER_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4
    } arb_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4
    } arb_state_t;
`endif

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    // Header byte announcing which requester owns the following frame.
    function automatic logic [7:0] hdr_byte(input logic [2:0] id);
        return {HDR_MAGIC, 1'b0, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr (wrapping).
// Ports: req_i (request vector), ptr_i (start position) -> onehot_o, id_o, vld_o (any request).
// Purely combinational, no state; reusable for any shared-resource arbiter.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [PTR_W-1:0] id_o,
    output logic             vld_o
);

    logic [2*N-1:0] rot;
    int             base;
    int             w;

    always_comb begin
        // Out-of-range pointer values fold back into 0..N-1.
        base     = int'(ptr_i) % N;
        rot      = {req_i, req_i} >> base;
        w        = 0;
        onehot_o = '0;
        id_o     = '0;
        vld_o    = 1'b0;
        // Scan from the far end so the smallest offset from ptr wins last.
        for (int off = N - 1; off >= 0; off--) begin
            if (rot[off]) begin
                w = base + off;
                if (w >= N) w = w - N;
                onehot_o = N'(1) << w;
                id_o     = PTR_W'(w);
                vld_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ byte-stream requesters, whole frames round-robin.
// Ports: clk12/rst (sync, active-high); req/req_data/req_last in, req_ack/grant out; busy;
//        tx_data/tx_start to uart_tx, tx_ready from it. Macro UART_ARB_FRAME_HEADER_EN adds a header byte.
module uart_tx_arbiter
    import uart_arb_defs::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk12,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_ready
);

    arb_state_t       state_q;
    logic [N_REQ-1:0] grant_q;
    logic [PTR_W-1:0] gid_q;
    logic [PTR_W-1:0] ptr_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic [N_REQ-1:0] req_ack_q;
    logic             last_q;

    logic [N_REQ-1:0] pick_oh;
    logic [PTR_W-1:0] pick_id;
    logic             pick_vld;

    logic [7:0]       cur_data;
    logic             cur_last;
    logic             cur_req;
    logic [PTR_W-1:0] next_ptr;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .id_o     (pick_id),
        .vld_o    (pick_vld)
    );

    // Only the granted requester's byte/last/req are ever looked at.
    always_comb begin
        cur_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (gid_q == PTR_W'(i)) cur_data = req_data[8*i +: 8];
        end
        cur_last = |(req_last & grant_q);
        cur_req  = |(req & grant_q);
        next_ptr = (gid_q == PTR_W'(N_REQ - 1)) ? '0 : gid_q + PTR_W'(1);
    end

    always_ff @(posedge clk12) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gid_q      <= '0;
            ptr_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            req_ack_q  <= '0;
            last_q     <= 1'b0;
        end else begin
            req_ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    // tx_ready gate also covers a reset that hit while uart_tx was still shifting.
                    if (pick_vld && tx_ready) begin
                        grant_q <= pick_oh;
                        gid_q   <= pick_id;
`ifdef UART_ARB_FRAME_HEADER_EN
                        state_q <= ST_HDR;
`else
                        state_q <= ST_LOAD;
`endif
                    end
                end
`ifdef UART_ARB_FRAME_HEADER_EN
                ST_HDR: begin
                    // Header never ends the frame and is not acknowledged.
                    tx_data_q <= hdr_byte(3'(gid_q));
                    last_q    <= 1'b0;
                    state_q   <= ST_START;
                end
`endif
                ST_LOAD: begin
                    tx_data_q <= cur_data;
                    last_q    <= cur_last;
                    req_ack_q <= grant_q;
                    state_q   <= ST_START;
                end
                ST_START: begin
                    // tx_ready is only trusted as an accept once our strobe is actually out.
                    if (tx_start_q && !tx_ready) begin
                        tx_start_q <= 1'b0;
                        state_q    <= ST_WAIT;
                    end else begin
                        tx_start_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (tx_ready) begin
                        if (last_q || !cur_req) begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            ptr_q   <= next_ptr;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant    = grant_q;
    assign req_ack  = req_ack_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with a behavioural uart_tx and requester models.
// Expected wire bytes and acks are queued by the stimulus and popped by monitors.
// Works with and without UART_ARB_FRAME_HEADER_EN.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_FRAME_HEADER_EN
    localparam int NHDR = 1;
`else
    localparam int NHDR = 0;
`endif
    localparam int TX_CYC = 20;   // 10 bit-times of 2 cycles

    typedef struct {
        int         r;
        logic [7:0] b;
    } ack_exp_t;

    logic        clk12 = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ack;
    logic [1:0]  grant;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_ready;

    logic [7:0] fr_dat [0:1][0:3];
    int         fr_len [0:1];
    int         idx    [0:1];
    int         acks   [0:1];

    logic       m_ready = 1'b1;
    int         m_cnt = 0;
    int         rise_cnt = 0;
    int         start_cnt = 0;

    logic [7:0] exp_wire [$];
    ack_exp_t   exp_ack  [$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk12 = ~clk12;

    uart_tx_arbiter #(.N_REQ(2)) dut (
        .clk12    (clk12),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready)
    );

    assign tx_ready = m_ready;

    // Requesters: present byte idx of their frame, advance on ack, wrap after last.
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            req_data[8*r +: 8] = fr_dat[r][idx[r]];
            req_last[r]        = (idx[r] == fr_len[r] - 1);
        end
    end

    always @(posedge clk12) begin
        for (int r = 0; r < 2; r++) begin
            if (rst) begin
                idx[r]  <= 0;
                acks[r] <= 0;
            end else if (req_ack[r]) begin
                idx[r]  <= (idx[r] + 1 == fr_len[r]) ? 0 : idx[r] + 1;
                acks[r] <= acks[r] + 1;
            end
        end
    end

    // uart_tx model: not affected by the arbiter's reset.
    always @(posedge clk12) begin
        if (m_ready && tx_start) begin
            m_ready   <= 1'b0;
            m_cnt     <= TX_CYC - 1;
            start_cnt <= start_cnt + 1;
        end else if (!m_ready) begin
            if (m_cnt == 0) begin
                m_ready  <= 1'b1;
                rise_cnt <= rise_cnt + 1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wire monitor: a byte is handed over when start meets ready.
    always @(negedge clk12) begin
        if (tx_start && tx_ready) begin
            if (exp_wire.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wire_unexpected: got byte %0h expected none", tx_data);
            end else begin
                chk("wire_byte", {24'h0, tx_data}, {24'h0, exp_wire.pop_front()});
            end
        end
    end

    // Ack monitor: which requester, and which byte got latched with it.
    always @(negedge clk12) begin
        if (req_ack != 2'b00) begin
            ack_exp_t e;
            int       r;
            r = req_ack[1] ? 1 : 0;
            chk("ack_onehot", $countones(req_ack), 1);
            if (exp_ack.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ack_unexpected: got ack %0b expected none", req_ack);
            end else begin
                e = exp_ack.pop_front();
                chk("ack_id", r, e.r);
                chk("ack_byte", {24'h0, tx_data}, {24'h0, e.b});
            end
        end
    end

    task automatic push_frame(input int r, input int n);
        if (NHDR != 0) exp_wire.push_back(8'hA0 + 8'(r));
        for (int k = 0; k < n; k++) begin
            ack_exp_t e;
            e.r = r;
            e.b = fr_dat[r][k];
            exp_wire.push_back(fr_dat[r][k]);
            exp_ack.push_back(e);
        end
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 2000 && (busy || !tx_ready); i++) @(negedge clk12);
        chk(nm, {31'h0, busy}, 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk12);
        rst = 1'b0;
    endtask

    initial begin
        int target;
        int base;
        int busy_cnt;
        logic bad;

        rst = 1'b1;
        req = 2'b00;
        fr_dat[0][0] = 8'h11; fr_dat[0][1] = 8'h22; fr_dat[0][2] = 8'h33; fr_dat[0][3] = 8'h00;
        fr_dat[1][0] = 8'h44; fr_dat[1][1] = 8'h55; fr_dat[1][2] = 8'h00; fr_dat[1][3] = 8'h00;
        fr_len[0] = 3;
        fr_len[1] = 2;
        repeat (3) @(negedge clk12);

        // Reset state
        chk("rst_grant", {30'h0, grant}, 0);
        chk("rst_ack", {30'h0, req_ack}, 0);
        chk("rst_start", {31'h0, tx_start}, 0);
        chk("rst_data", {24'h0, tx_data}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        rst = 1'b0;
        @(negedge clk12);

        // T1: 3-byte frame from req0, latency and release timing
        push_frame(0, 3);
        target = rise_cnt + 3 + NHDR;
        req[0] = 1'b1;
        @(negedge clk12);
        chk("t1_grant_lat", {30'h0, grant}, 2'b01);
        chk("t1_busy", {31'h0, busy}, 1);
        chk("t1_no_start_yet", {31'h0, tx_start}, 0);
        @(negedge clk12);
        if (NHDR == 0) chk("t1_ack_lat", {30'h0, req_ack}, 2'b01);
        @(negedge clk12);
        chk("t1_start_lat", {31'h0, tx_start}, 1);
        for (int i = 0; i < 3000 && rise_cnt < target; i++) begin
            if (acks[0] >= 3) req[0] = 1'b0;
            @(negedge clk12);
        end
        chk("t1_rises", rise_cnt, target);
        chk("t1_grant_held", {30'h0, grant}, 2'b01);
        @(negedge clk12);
        chk("t1_grant_clear", {30'h0, grant}, 0);
        chk("t1_acks", acks[0], 3);

        // Pointer now 1: both requesting, req1 must win
        push_frame(1, 2);
        req = 2'b11;
        @(negedge clk12);
        chk("t1_ptr_next", {30'h0, grant}, 2'b10);
        req[0] = 1'b0;
        for (int i = 0; i < 3000 && acks[1] < 2; i++) @(negedge clk12);
        req[1] = 1'b0;
        chk("t1b_acks", acks[1], 2);
        wait_idle("t1b_idle");

        // T2: simultaneous after reset (pointer 0): full req0 frame, then req1
        pulse_rst();
        push_frame(0, 3);
        push_frame(1, 2);
        req = 2'b11;
        for (int i = 0; i < 4000 && acks[1] < 2; i++) begin
            if (acks[1] >= 1) req[0] = 1'b0;
            @(negedge clk12);
        end
        req = 2'b00;
        chk("t2_r1_acks", acks[1], 2);
        chk("t2_r0_acks", acks[0], 3);
        wait_idle("t2_idle");

        // T3: req0 aborts after its first ack, req1 pending
        pulse_rst();
        push_frame(0, 1);
        push_frame(1, 2);
        req = 2'b11;
        for (int i = 0; i < 1000 && acks[0] < 1; i++) @(negedge clk12);
        req[0] = 1'b0;
        for (int i = 0; i < 1000 && grant == 2'b01; i++) @(negedge clk12);
        chk("t3_grant_clear", {30'h0, grant}, 0);
        for (int i = 0; i < 3000 && acks[1] < 2; i++) @(negedge clk12);
        req[1] = 1'b0;
        chk("t3_r1_acks", acks[1], 2);
        chk("t3_no_extra_ack", acks[0], 1);
        wait_idle("t3_idle");

        // T4: reset while in WAIT with tx_ready low
        pulse_rst();
        push_frame(0, 1 - NHDR);
        req[0] = 1'b1;
        for (int i = 0; i < 1000 && !(busy && !tx_start && !tx_ready); i++) @(negedge clk12);
        rst = 1'b1;
        req[0] = 1'b0;
        @(negedge clk12);
        rst = 1'b0;
        chk("t4_busy", {31'h0, busy}, 0);
        chk("t4_start", {31'h0, tx_start}, 0);
        chk("t4_grant", {30'h0, grant}, 0);
        push_frame(1, 2);
        req[1] = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 1000 && !tx_ready; i++) begin
            if (grant != 2'b00) bad = 1'b1;
            @(negedge clk12);
        end
        chk("t4_no_grant_while_busy", {31'h0, bad}, 0);
        @(negedge clk12);
        chk("t4_grant_after_ready", {30'h0, grant}, 2'b10);
        for (int i = 0; i < 3000 && acks[1] < 2; i++) @(negedge clk12);
        req[1] = 1'b0;
        wait_idle("t4_idle");

        // T5: 1-byte frame 8'h5A from req0: one start, exact busy window
        fr_dat[0][0] = 8'h5A;
        fr_len[0] = 1;
        push_frame(0, 1);
        base = start_cnt;
        busy_cnt = 0;
        req[0] = 1'b1;
        @(negedge clk12);
        chk("t5_busy_rise", {31'h0, busy}, 1);
        for (int i = 0; i < 500 && busy; i++) begin
            busy_cnt++;
            if (acks[0] >= 1) req[0] = 1'b0;
            @(negedge clk12);
        end
        req[0] = 1'b0;
        chk("t5_busy_cycles", busy_cnt, 24 * (1 + NHDR));
        chk("t5_starts", start_cnt - base, 1 + NHDR);
        chk("t5_acks", acks[0], 1);
        wait_idle("t5_idle");

        // T6: 1-byte frame from requester 1 (header 8'hA1 first when enabled)
        fr_dat[1][0] = 8'hC3;
        fr_len[1] = 1;
        push_frame(1, 1);
        req[1] = 1'b1;
        for (int i = 0; i < 1000 && acks[1] < 3; i++) @(negedge clk12);
        req[1] = 1'b0;
        chk("t6_acks", acks[1], 3);
        wait_idle("t6_idle");

        repeat (5) @(negedge clk12);
        chk("sb_wire_drained", exp_wire.size(), 0);
        chk("sb_ack_drained", exp_ack.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
